// File: rtl/debounce_pkg.sv
// Shared constants, counter sizing helper and edge-pulse type for the debouncer.
package debounce_pkg;

  localparam int unsigned DEB_DEFAULT_STABLE = 3;
  localparam int unsigned DEB_DEFAULT_SYNC   = 2;

  typedef struct packed {
    logic rise;
    logic fall;
  } deb_edge_t;

  // Counter only needs to reach stable-1; never narrower than one bit.
  function automatic int unsigned deb_cnt_width(input int unsigned stable);
    return (stable <= 2) ? 1 : $clog2(stable);
  endfunction

endpackage

// File: rtl/multi_debouncer_if.sv
// Pin-side bundle of the multi-channel debouncer: raw inputs, strobe and filtered outputs.
interface multi_debouncer_if #(
  parameter int unsigned NUM_CH = 4
);
  logic              sample_en;
  logic [NUM_CH-1:0] sig_in;
  logic [NUM_CH-1:0] sig_out;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic              any_change;

  modport master (
    output sample_en, sig_in,
    input  sig_out, rise, fall, any_change
  );

  modport slave (
    input  sample_en, sig_in,
    output sig_out, rise, fall, any_change
  );
endinterface

// File: rtl/debounce_channel.sv
// One debounce lane: optional synchroniser, stability counter, output flop and edge pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEB_DEFAULT_STABLE,
  parameter int unsigned SYNC_STAGES   = DEB_DEFAULT_SYNC,
  parameter logic        RESET_VAL     = 1'b0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      sample_en,
  input  logic      din,
  output logic      dout,
  output deb_edge_t pulse,
  output logic      flip
);

  localparam int unsigned    CW      = deb_cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic          s;
  logic [CW-1:0] cnt;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = din;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] chain;

    // Runs every clock, independent of sample_en, so metastability settles regardless of prescaling.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        chain <= {SYNC_STAGES{RESET_VAL}};
      end else begin
        for (int unsigned k = SYNC_STAGES - 1; k > 0; k--) begin
          chain[k] <= chain[k-1];
        end
        chain[0] <= din;
      end
    end

    assign s = chain[SYNC_STAGES-1];
  end

  assign flip = sample_en && (s != dout) && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout  <= RESET_VAL;
      cnt   <= '0;
      pulse <= '0;
    end else begin
      pulse <= '0;
      if (sample_en) begin
        if (s == dout) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          dout       <= ~dout;
          cnt        <= '0;
          pulse.rise <= ~dout;
          pulse.fall <= dout;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/multi_debouncer.sv
// N-channel switch debouncer: independent lanes plus a registered any-transition flag.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned STABLE_CYCLES = DEB_DEFAULT_STABLE,
  parameter int unsigned SYNC_STAGES   = DEB_DEFAULT_SYNC,
  parameter logic        RESET_VAL     = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  multi_debouncer_if.slave   bus
);

  logic [NUM_CH-1:0] out_v;
  logic [NUM_CH-1:0] rise_v;
  logic [NUM_CH-1:0] fall_v;
  logic [NUM_CH-1:0] flip_v;
  deb_edge_t         pulse_v [NUM_CH];
  logic              any_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES),
      .RESET_VAL     (RESET_VAL)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (bus.sample_en),
      .din       (bus.sig_in[i]),
      .dout      (out_v[i]),
      .pulse     (pulse_v[i]),
      .flip      (flip_v[i])
    );

    assign rise_v[i] = pulse_v[i].rise;
    assign fall_v[i] = pulse_v[i].fall;
  end

  // Registered from the lanes' next-state flip terms so it lines up with rise/fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_q <= 1'b0;
    end else begin
      any_q <= |flip_v;
    end
  end

  assign bus.sig_out    = out_v;
  assign bus.rise       = rise_v;
  assign bus.fall       = fall_v;
  assign bus.any_change = any_q;

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer across four parameter sets.
module tb_multi_debouncer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c, rst_d;

  multi_debouncer_if #(.NUM_CH(4)) ifa ();
  multi_debouncer_if #(.NUM_CH(4)) ifb ();
  multi_debouncer_if #(.NUM_CH(4)) ifc ();
  multi_debouncer_if #(.NUM_CH(4)) ifd ();

  multi_debouncer #(.NUM_CH(4), .STABLE_CYCLES(3), .SYNC_STAGES(2), .RESET_VAL(1'b0))
    u_a (.clk(clk), .rst_n(rst_a), .bus(ifa));
  multi_debouncer #(.NUM_CH(4), .STABLE_CYCLES(4), .SYNC_STAGES(2), .RESET_VAL(1'b0))
    u_b (.clk(clk), .rst_n(rst_b), .bus(ifb));
  multi_debouncer #(.NUM_CH(4), .STABLE_CYCLES(1), .SYNC_STAGES(0), .RESET_VAL(1'b0))
    u_c (.clk(clk), .rst_n(rst_c), .bus(ifc));
  multi_debouncer #(.NUM_CH(4), .STABLE_CYCLES(3), .SYNC_STAGES(2), .RESET_VAL(1'b1))
    u_d (.clk(clk), .rst_n(rst_d), .bus(ifd));

  typedef struct {
    logic       se;
    logic [3:0] in;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any;
  } vec_t;

  vec_t tv[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input logic se, input logic [3:0] in, input logic [3:0] out,
                     input logic [3:0] rise, input logic [3:0] fall, input logic any);
    vec_t v;
    v.se = se; v.in = in; v.out = out; v.rise = rise; v.fall = fall; v.any = any;
    tv.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk4(input string tag,
                      input logic [3:0] o_act, input logic [3:0] r_act,
                      input logic [3:0] f_act, input logic a_act,
                      input logic [3:0] o_exp, input logic [3:0] r_exp,
                      input logic [3:0] f_exp, input logic a_exp);
    check({tag, ".sig_out"},    {4'h0, o_act}, {4'h0, o_exp});
    check({tag, ".rise"},       {4'h0, r_act}, {4'h0, r_exp});
    check({tag, ".fall"},       {4'h0, f_act}, {4'h0, f_exp});
    check({tag, ".any_change"}, {7'h0, a_act}, {7'h0, a_exp});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [0:7] pat;
  logic [3:0] cvals [12];
  logic [3:0] prev;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    ifa.sample_en = 1'b1; ifa.sig_in = 4'h0;
    ifb.sample_en = 1'b1; ifb.sig_in = 4'h0;
    ifc.sample_en = 1'b1; ifc.sig_in = 4'h0;
    ifd.sample_en = 1'b1; ifd.sig_in = 4'hF;

    // u_a sequence after a reset released with sig_in already F
    for (int i = 0; i < 4; i++) add(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
    add(1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1);
    add(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) add(1'b1, 4'hD, 4'hF, 4'h0, 4'h0, 1'b0);
    add(1'b1, 4'hD, 4'hD, 4'h0, 4'h2, 1'b1);
    add(1'b1, 4'hD, 4'hD, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 4; i++) add(1'b1, 4'h7, 4'hD, 4'h0, 4'h0, 1'b0);
    add(1'b1, 4'h7, 4'h7, 4'h2, 4'h8, 1'b1);
    add(1'b1, 4'h7, 4'h7, 4'h0, 4'h0, 1'b0);
    add(1'b1, 4'h6, 4'h7, 4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 6; i++) add(1'b1, 4'h7, 4'h7, 4'h0, 4'h0, 1'b0);

    tick; tick;
    chk4("rst_a", ifa.sig_out, ifa.rise, ifa.fall, ifa.any_change, 4'h0, 4'h0, 4'h0, 1'b0);
    chk4("rst_d", ifd.sig_out, ifd.rise, ifd.fall, ifd.any_change, 4'hF, 4'h0, 4'h0, 1'b0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;

    // RESET_VAL=1 with inputs held high: never a pulse
    for (int i = 0; i < 8; i++) begin
      tick;
      chk4($sformatf("rv1_hold%0d", i), ifd.sig_out, ifd.rise, ifd.fall, ifd.any_change,
           4'hF, 4'h0, 4'h0, 1'b0);
    end

    // First step to F, then asynchronous reset while rise is high
    ifa.sig_in = 4'hF;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk4($sformatf("step_wait%0d", i), ifa.sig_out, ifa.rise, ifa.fall, ifa.any_change,
           4'h0, 4'h0, 4'h0, 1'b0);
    end
    tick;
    chk4("step_flip", ifa.sig_out, ifa.rise, ifa.fall, ifa.any_change, 4'hF, 4'hF, 4'h0, 1'b1);
    #4 rst_a = 1'b0;
    #1 chk4("async_rst", ifa.sig_out, ifa.rise, ifa.fall, ifa.any_change, 4'h0, 4'h0, 4'h0, 1'b0);
    tick; tick;
    rst_a = 1'b1;

    foreach (tv[i]) begin
      ifa.sample_en = tv[i].se;
      ifa.sig_in    = tv[i].in;
      tick;
      chk4($sformatf("vec%0d", i), ifa.sig_out, ifa.rise, ifa.fall, ifa.any_change,
           tv[i].out, tv[i].rise, tv[i].fall, tv[i].any);
    end

    // sample_en one cycle in four, ch2 falls: enabled samples at k=3,7,11 -> flip on k=11
    for (int k = 0; k < 16; k++) begin
      ifa.sample_en = ((k % 4) == 3);
      ifa.sig_in    = 4'h3;
      tick;
      chk4($sformatf("gate%0d", k), ifa.sig_out, ifa.rise, ifa.fall, ifa.any_change,
           (k >= 11) ? 4'h3 : 4'h7, 4'h0, (k == 11) ? 4'h4 : 4'h0, (k == 11));
    end
    ifa.sample_en = 1'b1;

    // Reset mid-count discards partial progress
    rst_a = 1'b0; ifa.sig_in = 4'h0;
    tick;
    rst_a = 1'b1;
    tick;
    ifa.sig_in = 4'h1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk4($sformatf("midcnt%0d", i), ifa.sig_out, ifa.rise, ifa.fall, ifa.any_change,
           4'h0, 4'h0, 4'h0, 1'b0);
    end
    #4 rst_a = 1'b0;
    #1 chk4("midcnt_rst", ifa.sig_out, ifa.rise, ifa.fall, ifa.any_change, 4'h0, 4'h0, 4'h0, 1'b0);
    tick;
    rst_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk4($sformatf("rewin%0d", i), ifa.sig_out, ifa.rise, ifa.fall, ifa.any_change,
           4'h0, 4'h0, 4'h0, 1'b0);
    end
    tick;
    chk4("rewin_flip", ifa.sig_out, ifa.rise, ifa.fall, ifa.any_change, 4'h1, 4'h1, 4'h0, 1'b1);

    // Bounce rejection on u_b (window 4): flip only after the solid run, on p=13
    pat = 8'b1110_1110;
    for (int p = 0; p < 16; p++) begin
      ifb.sig_in = {3'b000, (p < 8) ? pat[p] : 1'b1};
      tick;
      chk4($sformatf("bounce%0d", p), ifb.sig_out, ifb.rise, ifb.fall, ifb.any_change,
           (p >= 13) ? 4'h1 : 4'h0, (p == 13) ? 4'h1 : 4'h0, 4'h0, (p == 13));
    end

    // STABLE_CYCLES=1, no synchroniser: output is input delayed by one edge
    cvals = '{4'h1, 4'h1, 4'h0, 4'h3, 4'hC, 4'hF, 4'h0, 4'h5, 4'hA, 4'hA, 4'h6, 4'h9};
    prev  = 4'h0;
    for (int j = 0; j < 12; j++) begin
      ifc.sig_in = cvals[j];
      tick;
      chk4($sformatf("track%0d", j), ifc.sig_out, ifc.rise, ifc.fall, ifc.any_change,
           cvals[j], cvals[j] & ~prev, ~cvals[j] & prev, (cvals[j] != prev));
      prev = cvals[j];
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
